// File: rtl/thread_fetch_sched.sv
// Barrel-thread fetch scheduler: strict round-robin over per-thread PC/ready state,
// issuing selected PCs through a fixed-latency fetch register chain.
module thread_fetch_sched #(
  parameter int                    NUM_THREADS  = 32,
  parameter int                    TID_WIDTH    = $clog2(NUM_THREADS),
  parameter int                    ADDR_WIDTH   = 11,
  parameter logic [ADDR_WIDTH-1:0] STARTUP_ADDR = '0,
  parameter int                    FETCH_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  pc_wr_en,
  input  logic [TID_WIDTH-1:0]  pc_wr_tid,
  input  logic [ADDR_WIDTH-1:0] pc_wr_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  fetch_valid,
  output logic [TID_WIDTH-1:0]  fetch_tid,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  wr_err
);

  typedef struct packed {
    logic                  valid;
    logic [TID_WIDTH-1:0]  tid;
    logic [ADDR_WIDTH-1:0] addr;
  } slot_t;

  logic [ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] ready;
  logic [TID_WIDTH-1:0]  sel;
  slot_t                 chain [FETCH_STAGES];
  slot_t                 push;
  logic                  wr_hit_ready;

  // Select decision reads only registered state: a same-cycle write-back is not bypassed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    push         = '0;
    wr_hit_ready = 1'b0;
    push.valid   = en & ready[sel];
    push.tid     = sel;
    push.addr    = pc[sel];
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (pc_wr_tid == TID_WIDTH'(i)) wr_hit_ready = ready[i];
    end
  end

  // Per-thread state; a write-back's set of ready takes priority over the issue clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the PC table lives in flops and must come out of reset at STARTUP_ADDR,
      // so it is reset like any other register rather than left as an unreset RAM.
      for (int i = 0; i < NUM_THREADS; i++) pc[i] <= STARTUP_ADDR;
      ready <= '1;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every read sees the
        // pre-edge value regardless of statement order.
        if (pc_wr_en && pc_wr_tid == TID_WIDTH'(i)) begin
          pc[i]    <= pc_wr_addr;
          ready[i] <= 1'b1;
        end else if (en && sel == TID_WIDTH'(i)) begin
          ready[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel    <= '0;
      wr_err <= 1'b0;
    end else begin
      if (en) sel <= (sel == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : sel + 1'b1;
      if (pc_wr_en && wr_hit_ready) wr_err <= 1'b1;
    end
  end

  // Fetch chain never stalls; en only turns the entering slot into a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < FETCH_STAGES; k++) chain[k] <= '0;
    end else begin
      chain[0] <= push;
      for (int k = 1; k < FETCH_STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign fetch_valid = chain[FETCH_STAGES-1].valid;
  assign fetch_tid   = chain[FETCH_STAGES-1].tid;
  assign fetch_pc    = chain[FETCH_STAGES-1].addr;
  assign imem_addr   = chain[FETCH_STAGES-1].addr;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Directed bench for thread_fetch_sched: a 32-thread/2-stage instance through startup,
// write-back, freeze, error and mid-stream reset, plus a 5-thread/1-stage instance.
module tb_thread_fetch_sched;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        pc_wr_en;
  logic [4:0]  pc_wr_tid;
  logic [10:0] pc_wr_addr;
  logic [10:0] imem_addr;
  logic        fetch_valid;
  logic [4:0]  fetch_tid;
  logic [10:0] fetch_pc;
  logic        wr_err;

  logic [10:0] f5_imem_addr;
  logic        f5_valid;
  logic [2:0]  f5_tid;
  logic [10:0] f5_pc;
  logic        f5_wr_err;

  int total = 0;
  int bad   = 0;

  thread_fetch_sched #(
    .NUM_THREADS(32), .ADDR_WIDTH(11), .FETCH_STAGES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en),
    .pc_wr_en(pc_wr_en), .pc_wr_tid(pc_wr_tid), .pc_wr_addr(pc_wr_addr),
    .imem_addr(imem_addr), .fetch_valid(fetch_valid), .fetch_tid(fetch_tid),
    .fetch_pc(fetch_pc), .wr_err(wr_err)
  );

  thread_fetch_sched #(
    .NUM_THREADS(5), .ADDR_WIDTH(11), .FETCH_STAGES(1)
  ) dut5 (
    .clk(clk), .resetn(resetn), .en(1'b1),
    .pc_wr_en(1'b0), .pc_wr_tid(3'd0), .pc_wr_addr(11'd0),
    .imem_addr(f5_imem_addr), .fetch_valid(f5_valid), .fetch_tid(f5_tid),
    .fetch_pc(f5_pc), .wr_err(f5_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase-1 schedule: en is low for select cycles 76..79, holding sel at 12.
  function automatic int exp_sel1(input int s);
    if (s < 76) return s % 32;
    if (s < 80) return 12;
    return (s - 4) % 32;
  endfunction

  function automatic logic exp_valid1(input int s);
    return (s >= 0 && s <= 31) || s == 37 || s == 71 || s == 80;
  endfunction

  // PC seen by a select in cycle s; a write-back in cycle w is visible from w+1.
  function automatic logic [10:0] exp_pc1(input int s, input int t);
    if (t == 5  && s > 10) return 11'h010;
    if (t == 7  && s > 39) return 11'h020;
    if (t == 12 && s > 70) return 11'h0C0;
    return 11'h000;
  endfunction

  initial begin
    int s;
    int t;
    resetn     = 1'b0;
    en         = 1'b1;
    pc_wr_en   = 1'b0;
    pc_wr_tid  = '0;
    pc_wr_addr = '0;
    #12;
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_imem",  32'(imem_addr),   32'd0);
    check("rst_tid",   32'(fetch_tid),   32'd0);
    check("rst_pc",    32'(fetch_pc),    32'd0);
    check("rst_err",   32'(wr_err),      32'd0);
    check("rst_v5",    32'(f5_valid),    32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Phase 1: startup pass, write-backs to tid 5/7/12, en freeze at sel=12.
    for (int c = 0; c <= 90; c++) begin
      s = c - 2;
      t = (s < 0) ? 0 : exp_sel1(s);
      check($sformatf("p1_valid_c%0d", c), 32'(fetch_valid), 32'(exp_valid1(s)));
      check($sformatf("p1_tid_c%0d", c),   32'(fetch_tid),   32'(t));
      check($sformatf("p1_pc_c%0d", c),    32'(fetch_pc),    32'((s < 0) ? 11'h0 : exp_pc1(s, t)));
      check($sformatf("p1_imem_c%0d", c),  32'(imem_addr),   32'((s < 0) ? 11'h0 : exp_pc1(s, t)));
      check($sformatf("p1_err_c%0d", c),   32'(wr_err),      32'd0);
      if (c <= 12) begin
        check($sformatf("n5_valid_c%0d", c), 32'(f5_valid), 32'(c >= 1 && c <= 5));
        check($sformatf("n5_tid_c%0d", c),   32'(f5_tid),   32'((c == 0) ? 0 : (c - 1) % 5));
      end
      pc_wr_en   = (c == 10 || c == 39 || c == 70);
      pc_wr_tid  = (c == 10) ? 5'd5 : (c == 39) ? 5'd7 : 5'd12;
      pc_wr_addr = (c == 10) ? 11'h010 : (c == 39) ? 11'h020 : 11'h0C0;
      en         = !(c >= 76 && c <= 79);
      tick();
    end

    // Phase 2: legitimate write-back to tid 3, then a second one while ready[3]=1.
    pc_wr_en   = 1'b1;
    pc_wr_tid  = 5'd3;
    pc_wr_addr = 11'h030;
    tick();
    check("err_after_legal_wb", 32'(wr_err), 32'd0);
    pc_wr_addr = 11'h031;
    tick();
    pc_wr_en = 1'b0;
    check("err_set", 32'(wr_err), 32'd1);
    tick();
    tick();
    check("err_sticky", 32'(wr_err), 32'd1);

    // Mid-cycle asynchronous reset.
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(fetch_valid), 32'd0);
    check("mid_rst_imem",  32'(imem_addr),   32'd0);
    check("mid_rst_tid",   32'(fetch_tid),   32'd0);
    check("mid_rst_pc",    32'(fetch_pc),    32'd0);
    check("mid_rst_err",   32'(wr_err),      32'd0);
    check("mid_rst_v5",    32'(f5_valid),    32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Phase 3: startup repeats; write to tid 3 while it is selected and still ready.
    for (int c = 0; c <= 40; c++) begin
      s = c - 2;
      check($sformatf("p3_valid_c%0d", c), 32'(fetch_valid),
            32'((s >= 0 && s <= 31) || s == 35));
      check($sformatf("p3_tid_c%0d", c),   32'(fetch_tid), 32'((s < 0) ? 0 : s % 32));
      check($sformatf("p3_pc_c%0d", c),    32'(fetch_pc),
            32'((s > 3 && s % 32 == 3) ? 11'h077 : 11'h000));
      check($sformatf("p3_err_c%0d", c),   32'(wr_err), 32'(c >= 4));
      pc_wr_en   = (c == 3);
      pc_wr_tid  = 5'd3;
      pc_wr_addr = 11'h077;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
